// File: rtl/mmio_bus_ctrl.sv
// Memory-mapped data-bus controller: decodes processor accesses onto NUM_CH req/ack slave channels.
// Optional bus-error timeout is compiled in with `define MMIO_TIMEOUT_EN.
module mmio_bus_ctrl #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int NUM_CH      = 4,
  parameter int SEL_W       = $clog2(NUM_CH),
  parameter int TIMEOUT_CYC = 255,
  parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(16'hDEAD)
) (
  input  logic                     Clock,
  input  logic                     ResetN,
  input  logic                     ReadData,
  input  logic                     WriteData,
  input  logic [ADDR_W-1:0]        DataAddr,
  input  logic [DATA_W-1:0]        DataOut,
  output logic [DATA_W-1:0]        DataIn,
  output logic                     DataDone,
  output logic                     BusError,
  output logic [NUM_CH-1:0]        ch_req,
  output logic                     ch_we,
  output logic [ADDR_W-SEL_W-1:0]  ch_addr,
  output logic [DATA_W-1:0]        ch_wdata,
  input  logic [NUM_CH*DATA_W-1:0] ch_rdata,
  input  logic [NUM_CH-1:0]        ch_ack,
  output logic [1:0]               dbg_state
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Handshake: a channel sees ch_req[k] held high with stable ch_we/ch_addr/ch_wdata
  // until it returns ch_ack[k]; the processor holds ReadData/WriteData until DataDone.

  logic [1:0]        state;
  logic [SEL_W-1:0]  sel_q;
  logic [SEL_W-1:0]  sel;
  logic              ack_sel;
  logic              timeout;
  logic [DATA_W-1:0] rdata_sel;

  assign sel       = DataAddr[ADDR_W-1 -: SEL_W];
  assign ack_sel   = ch_ack[sel_q];
  assign dbg_state = state;

  always_comb begin
    rdata_sel = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (sel_q == SEL_W'(k)) rdata_sel = ch_rdata[k*DATA_W +: DATA_W];
    end
  end

`ifdef MMIO_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] wait_cnt;

  assign timeout = (wait_cnt == CNT_W'(TIMEOUT_CYC));

  // Counter restarts on each new access and never passes TIMEOUT_CYC, since reaching it ends REQ.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      wait_cnt <= '0;
      BusError <= 1'b0;
    end else begin
      if (state == IDLE && (ReadData || WriteData)) begin
        wait_cnt <= '0;
      end else if (state == REQ && !ack_sel) begin
        if (timeout) BusError <= 1'b1;
        else         wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end
`else
  logic [31:0] unused_timeout_cyc;

  assign unused_timeout_cyc = TIMEOUT_CYC;
  assign timeout            = 1'b0;
  assign BusError           = 1'b0;
`endif

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state    <= IDLE;
      sel_q    <= '0;
      DataIn   <= '0;
      DataDone <= 1'b0;
      ch_req   <= '0;
      ch_we    <= 1'b0;
      ch_addr  <= '0;
      ch_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (WriteData || ReadData) begin
            sel_q    <= sel;
            ch_addr  <= DataAddr[ADDR_W-SEL_W-1:0];
            ch_wdata <= DataOut;
            ch_we    <= WriteData;
            ch_req   <= NUM_CH'(1) << sel;
            state    <= REQ;
          end
        end
        REQ: begin
          if (ack_sel) begin
            if (!ch_we) DataIn <= rdata_sel;
            ch_req <= '0;
            state  <= DONE;
          end else if (timeout) begin
            if (!ch_we) DataIn <= ERR_DATA;
            ch_req <= '0;
            state  <= DONE;
          end
        end
        DONE: begin
          // First DONE cycle arms the pulse; second carries DataDone while the processor releases.
          if (!DataDone) begin
            DataDone <= 1'b1;
          end else begin
            DataDone <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_bus_ctrl.sv
// Directed bench for mmio_bus_ctrl (NUM_CH=4, 16-bit data/address).
// Build with MMIO_TIMEOUT_EN to exercise the timeout path (TIMEOUT_CYC=8).
module tb_mmio_bus_ctrl;

`ifdef MMIO_TIMEOUT_EN
  localparam int TO_CYC = 8;
`else
  localparam int TO_CYC = 255;
`endif

  logic        clk;
  logic        rst_n;
  logic        read_data;
  logic        write_data;
  logic [15:0] data_addr;
  logic [15:0] data_out;
  logic [15:0] data_in;
  logic        data_done;
  logic        bus_error;
  logic [3:0]  ch_req;
  logic        ch_we;
  logic [13:0] ch_addr;
  logic [15:0] ch_wdata;
  logic [63:0] ch_rdata;
  logic [3:0]  ch_ack;
  logic [1:0]  dbg_state;

  int n_pass  = 0;
  int n_total = 0;
  logic dd_seen;

  mmio_bus_ctrl #(
    .DATA_W(16), .ADDR_W(16), .NUM_CH(4), .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .Clock(clk), .ResetN(rst_n), .ReadData(read_data), .WriteData(write_data),
    .DataAddr(data_addr), .DataOut(data_out), .DataIn(data_in), .DataDone(data_done),
    .BusError(bus_error), .ch_req(ch_req), .ch_we(ch_we), .ch_addr(ch_addr),
    .ch_wdata(ch_wdata), .ch_rdata(ch_rdata), .ch_ack(ch_ack), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    rst_n      = 1'b0;
    read_data  = 1'b1;
    write_data = 1'b0;
    data_addr  = 16'h4003;
    data_out   = 16'h0000;
    ch_rdata   = {16'h3333, 16'h2222, 16'h1234, 16'h1111};
    ch_ack     = 4'b0000;
    tick();
    tick();
    chk("rst_data_in",  32'(data_in),   32'h0);
    chk("rst_done",     32'(data_done), 32'h0);
    chk("rst_bus_err",  32'(bus_error), 32'h0);
    chk("rst_ch_req",   32'(ch_req),    32'h0);
    chk("rst_ch_we",    32'(ch_we),     32'h0);
    chk("rst_ch_addr",  32'(ch_addr),   32'h0);
    chk("rst_ch_wdata", 32'(ch_wdata),  32'h0);
    chk("rst_state",    32'(dbg_state), 32'h0);

    // read ch1 @4003, ack after 2 cycles
    rst_n = 1'b1;
    tick();
    chk("rd1_ch_req",  32'(ch_req),    32'h2);
    chk("rd1_ch_addr", 32'(ch_addr),   32'h0003);
    chk("rd1_ch_we",   32'(ch_we),     32'h0);
    tick();
    chk("rd1_wait_req",  32'(ch_req),    32'h2);
    chk("rd1_wait_done", 32'(data_done), 32'h0);
    ch_ack = 4'b0010;
    tick();
    ch_ack = 4'b0000;
    chk("rd1_req_drop", 32'(ch_req),    32'h0);
    chk("rd1_data_in",  32'(data_in),   32'h1234);
    chk("rd1_pre_done", 32'(data_done), 32'h0);
    tick();
    chk("rd1_done", 32'(data_done), 32'h1);
    read_data = 1'b0;
    tick();
    chk("rd1_done_pulse", 32'(data_done), 32'h0);
    chk("rd1_idle",       32'(dbg_state), 32'h0);

    // write BEEF to ch3 @C010, ack already present
    write_data = 1'b1;
    data_addr  = 16'hC010;
    data_out   = 16'hBEEF;
    ch_ack     = 4'b1000;
    tick();
    chk("wr_ch_req",   32'(ch_req),   32'h8);
    chk("wr_ch_we",    32'(ch_we),    32'h1);
    chk("wr_ch_wdata", 32'(ch_wdata), 32'hBEEF);
    chk("wr_ch_addr",  32'(ch_addr),  32'h0010);
    tick();
    chk("wr_cyc2_done", 32'(data_done), 32'h0);
    tick();
    chk("wr_cyc3_done", 32'(data_done), 32'h1);
    chk("wr_data_in",   32'(data_in),   32'h1234);
    write_data = 1'b0;
    ch_ack     = 4'b0000;
    tick();
    chk("wr_done_pulse", 32'(data_done), 32'h0);

    // read and write together: write wins, ch0
    read_data  = 1'b1;
    write_data = 1'b1;
    data_addr  = 16'h0005;
    data_out   = 16'h5A5A;
    tick();
    chk("rw_ch_req",   32'(ch_req),   32'h1);
    chk("rw_ch_we",    32'(ch_we),    32'h1);
    chk("rw_ch_addr",  32'(ch_addr),  32'h0005);
    chk("rw_ch_wdata", 32'(ch_wdata), 32'h5A5A);
    ch_ack = 4'b0001;
    tick();
    ch_ack = 4'b0000;
    tick();
    chk("rw_done",    32'(data_done), 32'h1);
    chk("rw_data_in", 32'(data_in),   32'h1234);
    read_data  = 1'b0;
    write_data = 1'b0;
    tick();

    // ack in IDLE is ignored
    ch_ack = 4'b1111;
    tick();
    tick();
    chk("idle_ack_state", 32'(dbg_state), 32'h0);
    chk("idle_ack_done",  32'(data_done), 32'h0);
    chk("idle_ack_req",   32'(ch_req),    32'h0);
    ch_ack = 4'b0000;

    // spurious ack on ch2 during ch0 read
    read_data = 1'b1;
    data_addr = 16'h0007;
    tick();
    ch_ack = 4'b0100;
    tick();
    tick();
    chk("spur_req_held", 32'(ch_req),    32'h1);
    chk("spur_state",    32'(dbg_state), 32'h1);
    chk("spur_no_done",  32'(data_done), 32'h0);
    ch_ack = 4'b0001;
    tick();
    ch_ack = 4'b0000;
    chk("spur_data_in", 32'(data_in), 32'h1111);
    tick();
    chk("spur_done", 32'(data_done), 32'h1);
    read_data = 1'b0;
    tick();

    // async reset while in REQ aborts the access
    read_data = 1'b1;
    data_addr = 16'h8002;
    tick();
    chk("abort_req_up", 32'(ch_req), 32'h4);
    rst_n = 1'b0;
    #1;
    chk("abort_req_async", 32'(ch_req),    32'h0);
    chk("abort_state",     32'(dbg_state), 32'h0);
    read_data = 1'b0;
    tick();
    rst_n   = 1'b1;
    dd_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (data_done) dd_seen = 1'b1;
    end
    chk("abort_no_done", 32'(dd_seen), 32'h0);

    // next access after abort completes normally
    read_data = 1'b1;
    ch_ack    = 4'b0100;
    tick();
    tick();
    ch_ack = 4'b0000;
    chk("post_abort_data", 32'(data_in), 32'h2222);
    tick();
    chk("post_abort_done", 32'(data_done), 32'h1);
    read_data = 1'b0;
    tick();

    // read with no ack at all
    read_data = 1'b1;
    data_addr = 16'hC001;
    dd_seen   = 1'b0;
`ifdef MMIO_TIMEOUT_EN
    for (int i = 0; i < 40 && !dd_seen; i++) begin
      tick();
      if (data_done) dd_seen = 1'b1;
    end
    chk("to_done",     32'(dd_seen),   32'h1);
    chk("to_data_in",  32'(data_in),   32'hDEAD);
    chk("to_bus_err",  32'(bus_error), 32'h1);
    read_data = 1'b0;
    ch_ack    = 4'b1000;
    tick();
    ch_ack = 4'b0000;
    tick();
    tick();
    chk("to_bus_err_sticky", 32'(bus_error), 32'h1);
`else
    for (int i = 0; i < 40; i++) begin
      tick();
      if (data_done) dd_seen = 1'b1;
    end
    chk("stall_no_done", 32'(dd_seen),   32'h0);
    chk("stall_state",   32'(dbg_state), 32'h1);
    chk("stall_bus_err", 32'(bus_error), 32'h0);
    chk("stall_req",     32'(ch_req),    32'h8);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mmio_bus_ctrl.md
Name: mmio_bus_ctrl

Overview:
Parametrised memory-mapped data-bus controller for the processor's data port. It decodes each processor read or write into one of NUM_CH slave channels, such as data RAM, HEX, LEDR/SW or KEY peripherals. Each slave channel has its own req/ack handshake with arbitrary wait states. The controller returns a single-cycle DataDone with registered read data. It sits between `processor` and the board peripherals in the top level, and generalises the fixed-map data bus to N channels.

Parameters:
- DATA_W, 16, data width of processor and channel data.
- ADDR_W, 16, processor data address width.
- NUM_CH, 4, number of slave channels (power of two, 2..16).
- SEL_W, $clog2(NUM_CH), channel-select bits; derived, not overridden.
- TIMEOUT_CYC, 255, max wait cycles before bus error. Used only with MMIO_TIMEOUT_EN.
- ERR_DATA, 16'hDEAD, read data returned on error.

Ports:
- Clock, in, 1, system clock; all state on rising edge.
- ResetN, in, 1, asynchronous active-low reset.
- ReadData, in, 1, processor read request; held until DataDone.
- WriteData, in, 1, processor write request; held until DataDone.
- DataAddr, in, ADDR_W, processor byte-free word address.
- DataOut, in, DATA_W, processor write data.
- DataIn, out, DATA_W, read data to processor; valid when DataDone=1.
- DataDone, out, 1, one-cycle completion pulse.
- BusError, out, 1, sticky error flag; cleared only by reset.
- ch_req, out, NUM_CH, one-hot channel request.
- ch_we, out, 1, write enable for the active channel.
- ch_addr, out, ADDR_W-SEL_W, channel-local address: DataAddr[ADDR_W-SEL_W-1:0].
- ch_wdata, out, DATA_W, write data.
- ch_rdata, in, NUM_CH*DATA_W, packed read data; channel k is at [k*DATA_W +: DATA_W].
- ch_ack, in, NUM_CH, per-channel acknowledge.

Behaviour:
- Channel select: sel = DataAddr[ADDR_W-1 -: SEL_W].
- Reset (ResetN=0, async): state=IDLE. DataIn=0, DataDone=0, BusError=0, ch_req=0, ch_we=0, ch_addr=0, ch_wdata=0, wait counter=0.
  - Reset mid-transaction aborts it immediately.
  - No DataDone is issued for the aborted access.
- FSM has three states: IDLE, REQ, DONE.
- IDLE:
  - If WriteData or ReadData: latch sel, ch_addr, ch_wdata=DataOut, ch_we=WriteData.
  - Assert ch_req[sel] the next cycle; go to REQ.
  - If both WriteData and ReadData are high, the write wins (ch_we=1).
- REQ:
  - ch_req[sel] is held high and all channel outputs are held stable.
  - On ch_ack[sel]=1: capture ch_rdata[sel] into DataIn (reads only; writes leave DataIn unchanged), drop ch_req, go to DONE.
  - ch_ack on non-selected channels is ignored.
- DONE: DataDone=1 for exactly one cycle, then go to IDLE.
  - The processor drops or changes its request in the DataDone cycle.
  - A request still high in IDLE the following cycle is treated as a new access.
- Latency: request sampled at edge N; ch_req high after N; ack at edge N+k (k≥1); DataDone high for one cycle after edge N+k+1.
  - Minimum 3 cycles request-to-DataDone; one access outstanding at a time.
- DataIn holds its last value between accesses.
- ch_ack arriving in IDLE or DONE is ignored.
- Wait counter counts REQ cycles and saturates at TIMEOUT_CYC; it resets on entry to REQ.

Optional Feature:
- Macro: MMIO_TIMEOUT_EN.
- Defined: if the counter reaches TIMEOUT_CYC in REQ without ack:
  - drop ch_req;
  - DataIn=ERR_DATA for reads;
  - set BusError=1;
  - go to DONE (DataDone pulses, so the processor does not hang).
  - A late ack after timeout is ignored.
- Undefined: no counter logic; REQ waits indefinitely for ack; BusError is tied to 0.

Test Plan:
- Reset: ResetN=0 with ReadData=1 → all outputs 0. Release, then read addr 16'h4003 (NUM_CH=4, sel=1) with ch1 ack after 2 cycles, ch_rdata ch1=16'h1234 → ch_req=4'b0010, ch_addr=14'h0003, DataIn=16'h1234, single DataDone pulse.
- Write 16'hBEEF to addr 16'hC010 with immediate ack → ch_req=4'b1000, ch_we=1, ch_wdata=16'hBEEF, DataDone 3 cycles after request, DataIn unchanged.
- Both ReadData and WriteData high at addr 16'h0005 → write performed on ch0 (ch_we=1).
- Spurious ch_ack[2] during a ch0 access → ignored; completion waits for ch_ack[0].
- ResetN asserted in REQ → ch_req drops asynchronously, no DataDone. Next access completes normally.
- MMIO_TIMEOUT_EN, TIMEOUT_CYC=8, read with no ack → DataDone after timeout, DataIn=16'hDEAD, BusError=1 and sticky. Without the macro, the same stimulus leaves DataDone at 0 indefinitely.
